mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
- Shares one pipelined signed multiplier between NUM_REQ requesters, with per-requester operand sign mode.
- Round-robin arbitration, at most one issue per cycle.
- In-flight tracking through a tag pipeline; results are returned in issue order through a credited response FIFO, so the multiplier never has to stall.
- Sits between requester engines and one `multiplier` instance configured with `DATA_WIDTH+1` and `SIGNED_MULT=1`.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, operand width per requester.
- MUL_LATENCY, 1, cycles from mul_a/mul_b registered to mul_p valid (≥1).
- FIFO_DEPTH, 4, response FIFO entries (≥ MUL_LATENCY+1).
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept.
- req_signed  in  NUM_REQ  1 = operands two's complement, 0 = unsigned.
- req_a  in  NUM_REQ*DATA_WIDTH  flattened operand A; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  flattened operand B.
- mul_a  out  DATA_WIDTH+1  extended operand A to multiplier.
- mul_b  out  DATA_WIDTH+1  extended operand B.
- mul_p  in  2*DATA_WIDTH+2  multiplier product.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  ID_W  originating requester.
- rsp_p  out  2*DATA_WIDTH  product.

Behaviour:
- The single clock is clk. Reset is synchronous and active-high on rst.
- Reset values:
  - req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_p=0.
  - rr_ptr=0, credits=FIFO_DEPTH.
  - FIFO empty; all tag-pipe valids cleared.
- Reset mid-operation: in-flight and buffered results are discarded. No rsp_valid appears afterward for pre-reset requests.
- Arbitration (combinational):
  - Grant exists only when registered credits>0.
  - The winner is the first i with req_valid[i], searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready is one-hot for the winner, all-zero otherwise.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - mul_a/mul_b register the extended operands: sign-extended if req_signed[winner], else zero-extended.
  - Tag {1, winner} enters tag pipe stage 0.
  - mul_a/mul_b hold their value when there is no accept.
- Tag pipe:
  - MUL_LATENCY stages deep, aligned so that the tag exits in the same cycle mul_p holds that operation's product.
  - On exit with valid=1, the FIFO writes {id, mul_p[2*DATA_WIDTH-1:0]}. Truncation is exact for both modes.
- Latency: an accept at edge E gives FIFO write at edge E+MUL_LATENCY+1. rsp_valid is high from that edge onward.
- FIFO: first-word-fall-through; rsp_valid = !empty; pop = rsp_valid & rsp_ready. Writes never hit full, guaranteed by credits.
- Credits:
  - Accept alone: credits-1.
  - Pop alone: credits+1.
  - Both in the same cycle: unchanged.
  - Range is 0..FIFO_DEPTH; an assertion flags any violation.
- Boundary: at credits=0 with a pop in the same cycle, there is no grant that cycle; the grant resumes the next cycle.
- Throughput: one issue per cycle sustained while rsp_ready=1.
- Ordering: responses are in global accept order.

Decomposition:
- Package mul_share_pkg:
  - function clog2;
  - localparams EXT_W=DATA_WIDTH+1 and PROD_W=2*DATA_WIDTH;
  - typedef for the response entry {id, product}.
- Sub-module mul_rsp_fifo: parameterised synchronous FWFT FIFO with sync active-high reset, occupancy not exported.
- Arbiter and tag pipe stay inline.

Test Plan:
All scenarios use NUM_REQ=4, DATA_WIDTH=8, MUL_LATENCY=1, FIFO_DEPTH=4, with a real multiplier(DATA_WIDTH=9, SIGNED_MULT=1).
1. Requester 0 unsigned: a=0xFF, b=0xFF, rsp_ready=1 -> rsp_valid exactly 2 edges after accept, rsp_id=0, rsp_p=0xFE01.
2. Requester 2 signed: a=0x80, b=0x02 -> rsp_id=2, rsp_p=0xFF00 (-256). Same operands unsigned on requester 3 -> rsp_p=0x0100.
3. All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1… one per cycle; responses in the same id order with correct products.
4. rsp_ready=0 with requester 1 held valid -> exactly 4 accepts, then req_ready=0. Raise rsp_ready for one cycle -> one pop, one new accept on the following cycle.
5. rst pulsed for one cycle with 2 operations in flight and 1 buffered -> no rsp_valid afterward until new requests. credits=4; a fresh a=3, b=5 request yields rsp_p=15.
6. Random unsigned and signed operands from all requesters, with random rsp_ready (1000 ops) -> scoreboard matches every product, no FIFO overflow, credits within 0..4.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
// Widths here describe the default 4-requester, 8-bit build.
package mul_share_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DFLT_NUM_REQ    = 4;
  localparam int DFLT_DATA_WIDTH = 8;
  localparam int EXT_W           = DFLT_DATA_WIDTH + 1;
  localparam int PROD_W          = 2 * DFLT_DATA_WIDTH;
  localparam int DFLT_ID_W       = clog2(DFLT_NUM_REQ);

  typedef struct packed {
    logic [DFLT_ID_W-1:0] id;
    logic [PROD_W-1:0]    product;
  } rsp_entry_t;

endpackage

// File: rtl/mul_rsp_fifo.sv
// First-word-fall-through response FIFO with synchronous active-high reset.
// Reads as zero while empty so the response port idles at zero.
module mul_rsp_fifo
  import mul_share_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign do_rd   = rd_en && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting must make a write into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(wr_en && count == CNT_W'(DEPTH)));
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing of one pipelined signed multiplier between requesters;
// results return in issue order through a credited FWFT response FIFO.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ     = DFLT_NUM_REQ,
  parameter int DATA_WIDTH  = DFLT_DATA_WIDTH,
  parameter int MUL_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int ID_W        = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_signed,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH:0]           mul_a,
  output logic [DATA_WIDTH:0]           mul_b,
  input  logic [2*DATA_WIDTH+1:0]       mul_p,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [2*DATA_WIDTH-1:0]       rsp_p
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [PW-1:0]   product;
  } entry_t;

  logic [ID_W-1:0]                     rr_ptr;
  logic [ID_W-1:0]                     winner;
  logic                                grant_found;
  logic                                grant;
  logic                                pop;
  logic [CW-1:0]                       credits;
  logic [DATA_WIDTH-1:0]               win_a;
  logic [DATA_WIDTH-1:0]               win_b;
  logic                                win_signed;
  logic [MUL_LATENCY:0]                tag_valid;
  logic [MUL_LATENCY:0][ID_W-1:0]      tag_id;
  entry_t                              wr_entry;
  entry_t                              rd_entry;
  logic                                unused_mul_msb;

  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        winner      = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Credits cover both in-flight operations and buffered results.
  assign grant      = grant_found && (credits != '0) && !rst;
  assign req_ready  = grant ? (NUM_REQ'(1) << winner) : '0;
  assign pop        = rsp_valid && rsp_ready;
  assign win_a      = req_a[winner*DATA_WIDTH +: DATA_WIDTH];
  assign win_b      = req_b[winner*DATA_WIDTH +: DATA_WIDTH];
  assign win_signed = req_signed[winner];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      credits <= CW'(FIFO_DEPTH);
    end else begin
      if (grant) begin
        rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        mul_a  <= {win_signed & win_a[DATA_WIDTH-1], win_a};
        mul_b  <= {win_signed & win_b[DATA_WIDTH-1], win_b};
      end
      case ({grant, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Stage 0 runs alongside mul_a/mul_b; the last stage lines up with mul_p.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[MUL_LATENCY-1:0], grant};
      tag_id    <= {tag_id[MUL_LATENCY-1:0], winner};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (credits <= CW'(FIFO_DEPTH));
  end

  assign wr_entry.id      = tag_id[MUL_LATENCY];
  assign wr_entry.product = mul_p[PW-1:0];
  assign unused_mul_msb   = ^mul_p[PW+1:PW];

  mul_rsp_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_valid[MUL_LATENCY]),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .valid   (rsp_valid)
  );

  assign rsp_id = rd_entry.id;
  assign rsp_p  = rd_entry.product;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed and randomised checks of mul_share_ctrl against a one-cycle
// signed 9x9 multiplier model and an in-order expected-response queue.
module tb_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [8:0]  mul_a;
  logic [8:0]  mul_b;
  logic [17:0] mul_p;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] p;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  logic [15:0] rr_tab [4];
  int          lat;
  int          cnt;
  int          ops;
  int          cycles;
  int          m_rr;
  int          m_credits;
  int          m_win;
  logic [3:0]  rv;
  logic [3:0]  rs;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rr;
  logic [3:0]  exp_ready;

  always #5 clk = ~clk;

  always @(posedge clk) mul_p <= 18'($signed(mul_a) * $signed(mul_b));

  mul_share_ctrl #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (8),
    .MUL_LATENCY (1),
    .FIFO_DEPTH  (4),
    .ID_W        (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_p      (rsp_p)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] s, input logic [31:0] a,
                               input logic [31:0] b, input logic ready);
    @(negedge clk);
    req_valid  = v;
    req_signed = s;
    req_a      = a;
    req_b      = b;
    rsp_ready  = ready;
    #1;
  endtask

  function automatic logic [15:0] expProd(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x;
    int y;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return 16'(x * y);
  endfunction

  // One isolated operation with rsp_ready held high.
  task automatic runSingle(input int id, input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [8:0] exp_mul_a, input logic [15:0] exp_p);
    logic [31:0] av;
    logic [31:0] bv;
    logic [3:0]  onehot;
    int          l;
    av = '0;
    bv = '0;
    av[id*8 +: 8] = a;
    bv[id*8 +: 8] = b;
    onehot = 4'(1 << id);
    applyStimulus(onehot, s ? onehot : 4'h0, av, bv, 1'b1);
    checkOutput("single_grant", 32'(req_ready), 32'(onehot));
    applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
    checkOutput("single_mul_a", 32'(mul_a), 32'(exp_mul_a));
    l = 0;
    while (!rsp_valid && l < 10) begin
      applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
      l++;
    end
    checkOutput("single_latency", l, 2);
    checkOutput("single_id", 32'(rsp_id), id);
    checkOutput("single_p", 32'(rsp_p), 32'(exp_p));
    applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
    checkOutput("single_drained", 32'(rsp_valid), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_signed = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    applyStimulus(4'hF, 4'h0, '0, '0, 1'b0);
    checkOutput("reset_req_ready", 32'(req_ready), 0);
    applyStimulus(4'h0, 4'h0, '0, '0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 0);
    checkOutput("reset_rsp_p", 32'(rsp_p), 0);
    checkOutput("reset_mul_a", 32'(mul_a), 0);
    checkOutput("reset_mul_b", 32'(mul_b), 0);

    // 1 and 2: single operations, unsigned and signed extension
    runSingle(0, 8'hFF, 8'hFF, 1'b0, 9'h0FF, 16'hFE01);
    runSingle(2, 8'h80, 8'h02, 1'b1, 9'h180, 16'hFF00);
    runSingle(3, 8'h80, 8'h02, 1'b0, 9'h080, 16'h0100);

    // 3: all requesters valid, one grant per cycle in rotation
    rr_tab[0] = 16'h0100; rr_tab[1] = 16'hFFFB; rr_tab[2] = 16'h009C; rr_tab[3] = 16'hC0FF;
    for (int k = 0; k < 11; k++) begin
      applyStimulus((k < 8) ? 4'hF : 4'h0, 4'b1010, 32'h810CFF10, 32'h7F0D0510, 1'b1);
      checkOutput("rr_grant", 32'(req_ready), (k < 8) ? (1 << (k % 4)) : 0);
      if (k >= 3) begin
        checkOutput("rr_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("rr_rsp_id", 32'(rsp_id), (k - 3) % 4);
        checkOutput("rr_rsp_p", 32'(rsp_p), 32'(rr_tab[(k - 3) % 4]));
      end
    end
    applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
    checkOutput("rr_drained", 32'(rsp_valid), 0);

    // 4: credit exhaustion with rsp_ready low, then a single pop
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0010, 4'h0, 32'h00000700, 32'h00000600, 1'b0);
      if (req_ready == 4'b0010) cnt++;
    end
    checkOutput("credit_accepts", cnt, 4);
    checkOutput("credit_stalled", 32'(req_ready), 0);
    applyStimulus(4'b0010, 4'h0, 32'h00000700, 32'h00000600, 1'b1);
    checkOutput("credit_zero_pop_no_grant", 32'(req_ready), 0);
    checkOutput("credit_head_valid", 32'(rsp_valid), 1);
    checkOutput("credit_head_id", 32'(rsp_id), 1);
    checkOutput("credit_head_p", 32'(rsp_p), 32'h002A);
    applyStimulus(4'b0010, 4'h0, 32'h00000700, 32'h00000600, 1'b0);
    checkOutput("credit_grant_resumes", 32'(req_ready), 32'b0010);
    applyStimulus(4'b0010, 4'h0, 32'h00000700, 32'h00000600, 1'b0);
    checkOutput("credit_one_only", 32'(req_ready), 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
      if (rsp_valid) begin
        cnt++;
        checkOutput("credit_drain_p", 32'(rsp_p), 32'h002A);
      end
    end
    checkOutput("credit_drain_count", cnt, 4);

    // 5: reset with two operations in flight and one buffered
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, 4'h0, 32'h00000011, 32'h00000011, 1'b0);
      checkOutput("rst_pre_grant", 32'(req_ready), 32'b0001);
    end
    applyStimulus(4'h0, 4'h0, '0, '0, 1'b0);
    checkOutput("rst_pre_buffered", 32'(rsp_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
      checkOutput("rst_no_stale_rsp", 32'(rsp_valid), 0);
    end
    checkOutput("rst_mul_a", 32'(mul_a), 0);
    runSingle(0, 8'h03, 8'h05, 1'b0, 9'h003, 16'h000F);

    // 6: random traffic against an arbitration/credit model and scoreboard
    m_rr = 1;
    m_credits = 4;
    ops = 0;
    cycles = 0;
    while (ops < 1000 && cycles < 20000) begin
      rv = 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      rr = ($urandom_range(0, 3) != 0);
      applyStimulus(rv, rs, ra, rb, rr);
      m_win = -1;
      if (m_credits > 0)
        for (int k = 0; k < 4; k++)
          if (m_win < 0 && rv[(m_rr + k) % 4]) m_win = (m_rr + k) % 4;
      exp_ready = (m_win >= 0) ? 4'(1 << m_win) : 4'h0;
      checkOutput("rand_grant", 32'(req_ready), 32'(exp_ready));
      if (rsp_valid && rr) begin
        if (sb.size() > 0) begin
          head = sb.pop_front();
          checkOutput("rand_rsp_id", 32'(rsp_id), 32'(head.id));
          checkOutput("rand_rsp_p", 32'(rsp_p), 32'(head.p));
          m_credits++;
        end else begin
          checkOutput("rand_spurious_rsp", 32'(rsp_valid), 0);
        end
      end
      if (m_win >= 0) begin
        sb.push_back('{id: 2'(m_win),
                       p: expProd(ra[m_win*8 +: 8], rb[m_win*8 +: 8], rs[m_win])});
        m_credits--;
        m_rr = (m_win + 1) % 4;
        ops++;
      end
      cycles++;
    end
    checkOutput("rand_ops_issued", ops, 1000);
    lat = 0;
    while (sb.size() > 0 && lat < 50) begin
      applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
      if (rsp_valid) begin
        head = sb.pop_front();
        checkOutput("rand_drain_id", 32'(rsp_id), 32'(head.id));
        checkOutput("rand_drain_p", 32'(rsp_p), 32'(head.p));
      end
      lat++;
    end
    checkOutput("rand_scoreboard_empty", sb.size(), 0);
    applyStimulus(4'h0, 4'h0, '0, '0, 1'b1);
    checkOutput("rand_final_idle", 32'(rsp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
